// File: rtl/multiplier_pkg.sv
// Shared definitions for the multiplier leak monitor: FSM encoding, the
// default run-cycle limit and width helpers.
package multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Default abort limit: twice the operand width plus a small margin.
  function automatic int default_timeout(input int width);
    return 2 * width + 4;
  endfunction

  // Bits needed to hold values 0..max_value.
  function automatic int count_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/multiplier_leak_monitor_if.sv
// Control, operand and result bundle of the multiplier leak monitor.
interface multiplier_leak_monitor_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
);
  logic                         start;
  logic                         mode;
  logic                         clear_stats;
  logic [CHANNELS*WIDTH-1:0]    multiplier;
  logic [CHANNELS*WIDTH-1:0]    multiplicand;
  logic [CHANNELS*2*WIDTH-1:0]  product;
  logic                         busy;
  logic                         done;
  logic                         leak_now;
  logic                         leak;
  logic                         timeout;
  logic [CNT_W-1:0]             skew;
  logic [CNT_W-1:0]             max_skew;
  logic [CNT_W-1:0]             leak_count;

  modport master (
    output start, mode, clear_stats, multiplier, multiplicand,
    input  product, busy, done, leak_now, leak, timeout, skew, max_skew, leak_count
  );

  modport slave (
    input  start, mode, clear_stats, multiplier, multiplicand,
    output product, busy, done, leak_now, leak, timeout, skew, max_skew, leak_count
  );
endinterface

// File: rtl/multiplier_ct.sv
// One shift-add multiplier channel, one iteration per cycle. In mode 0 it
// always runs WIDTH iterations; in mode 1 it stops after the highest set
// multiplier bit (at least one iteration).
module multiplier_ct
  import multiplier_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic [2*WIDTH-1:0] product,
  output logic               product_done
);
  localparam int IW = count_width(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] addend;
  logic [WIDTH-1:0]   bits;
  logic [IW-1:0]      remaining;
  logic [IW-1:0]      iters;
  logic               active;

  // Iteration count for the operands presented with start
  always_comb begin
    // NOTE: default assigned before any conditional so no latch is inferred.
    iters = IW'(WIDTH);
    if (mode) begin
      iters = IW'(1);
      for (int i = 0; i < WIDTH; i++) begin
        if (multiplier[i]) iters = IW'(i + 1);
      end
    end
  end

  // Shift-add datapath; product_done pulses on the cycle the last iteration lands
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      acc          <= '0;
      addend       <= '0;
      bits         <= '0;
      remaining    <= '0;
      active       <= 1'b0;
      product_done <= 1'b0;
    end else if (start) begin
      acc          <= '0;
      addend       <= {{WIDTH{1'b0}}, multiplicand};
      bits         <= multiplier;
      remaining    <= iters;
      active       <= 1'b1;
      product_done <= 1'b0;
    end else begin
      product_done <= 1'b0;
      if (active) begin
        if (bits[0]) acc <= acc + addend;
        addend    <= addend << 1;
        bits      <= bits >> 1;
        remaining <= remaining - IW'(1);
        if (remaining == IW'(1)) begin
          active       <= 1'b0;
          product_done <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/multiplier_leak_monitor.sv
// Timing-leak monitor: starts all multiplier channels together, records when
// each finishes, and reports the spread of finish times (skew) plus sticky
// leak statistics. A run that exceeds TIMEOUT cycles is reported as a leak.
module multiplier_leak_monitor
  import multiplier_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = default_timeout(WIDTH)
) (
  input logic                       clk,
  input logic                       rst,
  multiplier_leak_monitor_if.slave  bus
);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT =
    (TIMEOUT >= (2 ** CNT_W) - 1) ? '1 : CNT_W'(TIMEOUT);

  state_t                      state, state_nx;
  logic                        launch, busy_c, done_c;
  logic [CHANNELS-1:0]         ch_done, fin, fin_nx;
  logic [CHANNELS*2*WIDTH-1:0] ch_product, product_q;
  logic [CNT_W-1:0]            run_cnt, first_t, last_t, first_nx, last_nx, skew_nx;
  logic [CNT_W-1:0]            skew_q, max_skew_q, leak_count_q;
  logic                        any_fin, any_fin_nx, all_fin, expired;
  logic                        timeout_q, leak_now_q, leak_q;

  assign launch = (state == ST_IDLE) && bus.start;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    multiplier_ct #(.WIDTH(WIDTH)) u_ch (
      .clk          (clk),
      .rst          (rst),
      .start        (launch),
      .mode         (bus.mode),
      .multiplier   (bus.multiplier[c*WIDTH +: WIDTH]),
      .multiplicand (bus.multiplicand[c*WIDTH +: WIDTH]),
      .product      (ch_product[c*2*WIDTH +: 2*WIDTH]),
      .product_done (ch_done[c])
    );
  end

  // Finish bookkeeping including this cycle's done pulses, and the resulting skew
  always_comb begin
    fin_nx     = fin | ch_done;
    any_fin_nx = any_fin | (|ch_done);
    first_nx   = (!any_fin && (|ch_done)) ? run_cnt : first_t;
    last_nx    = (|ch_done) ? run_cnt : last_t;
    all_fin    = &fin_nx;
    expired    = !all_fin && (run_cnt >= TIMEOUT_CNT);
    skew_nx    = last_nx - first_nx;
    if (expired) skew_nx = any_fin_nx ? (TIMEOUT_CNT - first_nx) : TIMEOUT_CNT;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next state and status outputs
  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      ST_IDLE:   if (bus.start) state_nx = ST_RUN;
      ST_RUN: begin
        busy_c = 1'b1;
        if (all_fin || expired) state_nx = ST_REPORT;
      end
      ST_REPORT: begin
        busy_c   = 1'b1;
        done_c   = 1'b1;
        state_nx = ST_IDLE;
      end
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Run counter and finish-time tracking, restarted by each accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || launch) begin
      run_cnt <= '0;
      fin     <= '0;
      any_fin <= 1'b0;
      first_t <= '0;
      last_t  <= '0;
    end else if (state == ST_RUN) begin
      if (run_cnt != '1) run_cnt <= run_cnt + CNT_W'(1);
      fin     <= fin_nx;
      any_fin <= any_fin_nx;
      first_t <= first_nx;
      last_t  <= last_nx;
    end
  end

  // Per-run results, captured on entry to REPORT and held until the next one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skew_q     <= '0;
      timeout_q  <= 1'b0;
      leak_now_q <= 1'b0;
      product_q  <= '0;
    end else if (state == ST_RUN && state_nx == ST_REPORT) begin
      skew_q     <= skew_nx;
      timeout_q  <= expired;
      leak_now_q <= (skew_nx != '0) || expired;
      product_q  <= ch_product;
    end
  end

  // Sticky statistics; a clear coincident with REPORT keeps only this run's result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      leak_q       <= 1'b0;
      leak_count_q <= '0;
      max_skew_q   <= '0;
    end else if (state == ST_REPORT) begin
      if (bus.clear_stats) begin
        leak_q       <= leak_now_q;
        leak_count_q <= CNT_W'(leak_now_q);
        max_skew_q   <= skew_q;
      end else begin
        leak_q <= leak_q | leak_now_q;
        if (leak_now_q && leak_count_q != '1) leak_count_q <= leak_count_q + CNT_W'(1);
        if (skew_q > max_skew_q) max_skew_q <= skew_q;
      end
    end else if (bus.clear_stats) begin
      leak_q       <= 1'b0;
      leak_count_q <= '0;
      max_skew_q   <= '0;
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.skew       = skew_q;
  assign bus.timeout    = timeout_q;
  assign bus.leak_now   = leak_now_q;
  assign bus.product    = product_q;
  assign bus.leak       = leak_q;
  assign bus.leak_count = leak_count_q;
  assign bus.max_skew   = max_skew_q;

endmodule

// File: tb/tb_multiplier_leak_monitor.sv
// Bench for multiplier_leak_monitor: a default-TIMEOUT instance for normal
// runs and statistics, and a TIMEOUT=2 instance for the abort path.
module tb_multiplier_leak_monitor;
  localparam int W = 4;
  localparam int CH = 2;
  localparam int CW = 8;
  localparam int TMO_MAIN = 2 * W + 4;
  localparam int TMO_SHORT = 2;

  typedef struct {
    int       lat;
    int       skew;
    bit       to;
    bit [1:0] fin;
  } expect_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bit   m_leak;
  int   m_leak_count;
  int   m_max_skew;

  multiplier_leak_monitor_if #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) bus ();
  multiplier_leak_monitor_if #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) bus_t ();

  multiplier_leak_monitor #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );
  multiplier_leak_monitor #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW), .TIMEOUT(TMO_SHORT)) dut_t (
    .clk (clk), .rst (rst), .bus (bus_t.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Iterations a channel needs: full width, or bit length of the multiplier.
  function automatic int iters(input bit mode, input int m);
    if (!mode) return W;
    if (m == 0) return 1;
    return $clog2(m + 1);
  endfunction

  // Expected report timing and skew for one run against a given limit.
  function automatic expect_t model_run(input bit mode, input logic [7:0] mpl, input int tmo);
    expect_t e;
    int n, lo, hi;
    lo = 1 << 30;
    hi = 0;
    e.fin = '0;
    for (int c = 0; c < CH; c++) begin
      n = iters(mode, int'(mpl[c*W +: W]));
      if (n <= tmo) begin
        e.fin[c] = 1'b1;
        if (n < lo) lo = n;
        if (n > hi) hi = n;
      end
    end
    if (e.fin == 2'b11) begin
      e.to = 1'b0;
      e.skew = hi - lo;
      e.lat = hi + 1;
    end else begin
      e.to = 1'b1;
      e.skew = (e.fin != 0) ? tmo - lo : tmo;
      e.lat = tmo + 1;
    end
    return e;
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    bus.start = 0; bus.mode = 0; bus.clear_stats = 0; bus.multiplier = '0; bus.multiplicand = '0;
    bus_t.start = 0; bus_t.mode = 0; bus_t.clear_stats = 0; bus_t.multiplier = '0; bus_t.multiplicand = '0;
    m_leak = 0; m_leak_count = 0; m_max_skew = 0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.leak_now, bus.leak, bus.timeout, bus.skew, bus.max_skew,
         bus.leak_count, bus.product} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b skew=%0d product=%h want all zero",
               bus.busy, bus.done, bus.skew, bus.product);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One run on the main instance: latency, report values, products, statistics.
  task automatic run_main(input bit mode, input logic [7:0] mpl, input logic [7:0] mcd,
                          input bit inject, input bit clr, input string name);
    expect_t e;
    int lat;
    bit ln;
    int prod;
    e = model_run(mode, mpl, TMO_MAIN);
    bus.mode = mode; bus.multiplier = mpl; bus.multiplicand = mcd; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL %s busy: got %b want 1", name, bus.busy);
    end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (inject) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.mode = ~mode;
        bus.multiplier = 8'($urandom);
        bus.multiplicand = 8'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    if (clr) bus.clear_stats = 1'b1;
    checks++;
    if (lat !== e.lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
    end
    checks++;
    if (bus.skew !== 8'(e.skew) || bus.timeout !== e.to) begin
      errors++; $display("FAIL %s skew/timeout: got %0d/%b want %0d/%b", name, bus.skew, bus.timeout, e.skew, e.to);
    end
    ln = (e.skew != 0) || e.to;
    checks++;
    if (bus.leak_now !== ln) begin
      errors++; $display("FAIL %s leak_now: got %b want %b", name, bus.leak_now, ln);
    end
    for (int c = 0; c < CH; c++) begin
      prod = int'(mpl[c*W +: W]) * int'(mcd[c*W +: W]);
      checks++;
      if (bus.product[c*2*W +: 2*W] !== 8'(prod)) begin
        errors++; $display("FAIL %s product%0d: got %0d want %0d", name, c, bus.product[c*2*W +: 2*W], prod);
      end
    end
    if (clr) begin
      m_leak = ln; m_leak_count = int'(ln); m_max_skew = e.skew;
    end else begin
      m_leak = m_leak | ln;
      if (ln && m_leak_count < 255) m_leak_count++;
      if (e.skew > m_max_skew) m_max_skew = e.skew;
    end
    @(negedge clk);
    bus.clear_stats = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s idle: got done=%b busy=%b want 0 0", name, bus.done, bus.busy);
    end
    checks++;
    if (bus.leak !== m_leak || bus.leak_count !== 8'(m_leak_count) || bus.max_skew !== 8'(m_max_skew)) begin
      errors++;
      $display("FAIL %s stats: got leak=%b count=%0d max=%0d want %b %0d %0d",
               name, bus.leak, bus.leak_count, bus.max_skew, m_leak, m_leak_count, m_max_skew);
    end
    checks++;
    if (bus.skew !== 8'(e.skew) || bus.leak_now !== ln) begin
      errors++; $display("FAIL %s hold: got skew=%0d leak_now=%b want %0d %b", name, bus.skew, bus.leak_now, e.skew, ln);
    end
  endtask

  task automatic test_directed;
    run_main(1'b0, {4'd15, 4'd3}, {4'd15, 4'd5}, 1'b0, 1'b0, "const_time");
    run_main(1'b1, {4'b1000, 4'b0001}, {4'd7, 4'd7}, 1'b0, 1'b0, "early_term");
  endtask

  // Abort path on the TIMEOUT=2 instance.
  task automatic run_short(input bit mode, input logic [7:0] mpl, input logic [7:0] mcd, input string name);
    expect_t e;
    int lat;
    int prod;
    e = model_run(mode, mpl, TMO_SHORT);
    bus_t.mode = mode; bus_t.multiplier = mpl; bus_t.multiplicand = mcd; bus_t.start = 1'b1;
    @(negedge clk);
    bus_t.start = 1'b0;
    lat = 0;
    while (bus_t.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== e.lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
    end
    checks++;
    if (bus_t.skew !== 8'(e.skew) || bus_t.timeout !== e.to || bus_t.leak_now !== (e.to || e.skew != 0)) begin
      errors++;
      $display("FAIL %s report: got skew=%0d timeout=%b leak_now=%b want %0d %b %b",
               name, bus_t.skew, bus_t.timeout, bus_t.leak_now, e.skew, e.to, e.to || e.skew != 0);
    end
    for (int c = 0; c < CH; c++) begin
      if (e.fin[c]) begin
        prod = int'(mpl[c*W +: W]) * int'(mcd[c*W +: W]);
        checks++;
        if (bus_t.product[c*2*W +: 2*W] !== 8'(prod)) begin
          errors++; $display("FAIL %s product%0d: got %0d want %0d", name, c, bus_t.product[c*2*W +: 2*W], prod);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    run_short(1'b0, {4'd9, 4'd6}, {4'd3, 4'd11}, "timeout_none");
    run_short(1'b1, {4'd8, 4'd1}, {4'd5, 4'd13}, "timeout_partial");
    run_short(1'b1, {4'd2, 4'd3}, {4'd9, 4'd14}, "short_complete");
    for (int i = 0; i < 6; i++)
      run_short(1'b1, 8'($urandom), 8'($urandom), "timeout_rand");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++)
      run_main(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, "rand");
  endtask

  task automatic test_clear;
    run_main(1'b1, {4'd1, 4'd8}, {4'd3, 4'd2}, 1'b1, 1'b0, "leak_a");
    run_main(1'b1, {4'd4, 4'd1}, {4'd6, 4'd9}, 1'b1, 1'b0, "leak_b");
    run_main(1'b1, {4'd2, 4'd15}, {4'd1, 4'd12}, 1'b1, 1'b0, "leak_c");
    run_main(1'b0, {4'd1, 4'd8}, {4'd10, 4'd4}, 1'b1, 1'b1, "clear_at_report");
    run_main(1'b1, {4'd0, 4'd12}, {4'd7, 4'd7}, 1'b0, 1'b0, "leak_d");
    bus.clear_stats = 1'b1;
    @(negedge clk);
    bus.clear_stats = 1'b0;
    m_leak = 0; m_leak_count = 0; m_max_skew = 0;
    checks++;
    if ({bus.leak, bus.leak_count, bus.max_skew} !== '0) begin
      errors++;
      $display("FAIL clear_idle: got leak=%b count=%0d max=%0d want 0 0 0", bus.leak, bus.leak_count, bus.max_skew);
    end
  endtask

  task automatic test_reset_mid_run;
    int seen_done;
    run_main(1'b1, {4'd9, 4'd1}, {4'd4, 4'd5}, 1'b0, 1'b0, "pre_reset");
    bus.mode = 1'b0; bus.multiplier = 8'h35; bus.multiplicand = 8'h7e; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.leak_now, bus.leak, bus.timeout, bus.skew, bus.max_skew,
         bus.leak_count, bus.product} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b leak=%b count=%0d skew=%0d product=%h want all zero",
               bus.busy, bus.leak, bus.leak_count, bus.skew, bus.product);
    end
    m_leak = 0; m_leak_count = 0; m_max_skew = 0;
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++; $display("FAIL reset_no_done: got %0d done cycles want 0", seen_done);
    end
    rst = 1'b1;
    run_main(1'b0, {4'd6, 4'd11}, {4'd13, 4'd2}, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_timeout;
    test_random;
    test_clear;
    test_reset_mid_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplier_leak_monitor.md
MULTIPLIER_LEAK_MONITOR -- requirements
Module: multiplier_leak_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits.
REQ-002 SHALL have parameter CHANNELS, default 2, number of multiplier channels (>=2).
REQ-003 SHALL have parameter CNT_W, default 8, width of cycle, skew and statistics counters.
REQ-004 SHALL have parameter TIMEOUT, default 2*WIDTH+4, run-cycle limit before abort.
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1, begin a run; sampled in IDLE only.
REQ-008 SHALL have port mode, input, 1, 0 = constant-time channels, 1 = early-terminate channels; sampled with start.
REQ-009 SHALL have port clear_stats, input, 1, clear sticky statistics.
REQ-010 SHALL have ports multiplier and multiplicand, input, CHANNELS*WIDTH each, channel c at bits [c*WIDTH +: WIDTH].
REQ-011 SHALL have port product, output, CHANNELS*2*WIDTH, channel c at [c*2*WIDTH +: 2*WIDTH].
REQ-012 SHALL have ports busy, done, leak_now, leak, timeout, outputs, 1 each.
REQ-013 SHALL have ports skew, max_skew, leak_count, outputs, CNT_W each.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> REPORT -> IDLE; busy = 1 in RUN and REPORT.
REQ-015 IDLE: start=1 at an edge SHALL start all channels on that edge with their operands and mode, clear run counter and per-channel finish flags, enter RUN.
REQ-016 start while busy SHALL be ignored; no effect on the run in progress.
REQ-017 Each channel, with n iterations, SHALL pulse its internal done for exactly one cycle, n cycles after the start edge, product valid from that cycle until the next start.
REQ-018 mode 0: n = WIDTH for every operand value.
REQ-019 mode 1: n = index of highest set bit of multiplier + 1; multiplier = 0 gives n = 1.
REQ-020 Product SHALL equal multiplier*multiplicand, unsigned, full 2*WIDTH bits, no truncation.
REQ-021 RUN: run counter SHALL increment by 1 per cycle, saturating at 2^CNT_W-1; each channel's finish time = counter value in its done cycle; first and last finish times tracked.
REQ-022 Simultaneous done on several channels SHALL all be recorded in the same cycle.
REQ-023 RUN -> REPORT when all channels finished, or when counter reaches TIMEOUT with any channel unfinished (timeout path).
REQ-024 REPORT (one cycle): done = 1; skew = last - first finish time (timeout path: TIMEOUT - first, or TIMEOUT if none finished); timeout = 1 if timeout path; leak_now = (skew != 0) | timeout.
REQ-025 REPORT: leak |= leak_now; leak_count += leak_now, saturating at 2^CNT_W-1; max_skew = max(max_skew, skew).
REQ-026 skew, leak_now, timeout, product SHALL hold until the next REPORT or reset.
REQ-027 clear_stats SHALL zero leak, leak_count, max_skew in any state; when coincident with REPORT, clear applies first and the current run's update is then applied.
REQ-028 done SHALL be 0 outside REPORT.

Reset
REQ-029 rst low SHALL asynchronously force IDLE and zero every output, counter, finish flag and channel state.
REQ-030 rst asserted mid-RUN SHALL abort the run with no done pulse and no statistics update.
REQ-031 First start SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-032 FSM state encoding and the TIMEOUT default expression SHALL live in a shared package (multiplier_pkg) together with common width helpers.
REQ-033 Each channel SHALL be one instance of sub-module multiplier_ct (shift-add, one iteration per cycle, ports clk, rst, start, mode, multiplier, multiplicand, product, product_done), generated CHANNELS times.

Verification
REQ-034 WIDTH=4, CHANNELS=2, mode 0, ops (3,5),(15,15) -> done after 4 run cycles, products 15 and 225, skew 0, leak_now 0, leak 0.
REQ-035 mode 1, multipliers 4'b0001 and 4'b1000, multiplicand 7 -> finish times 1 and 4, skew 3, leak 1, leak_count 1, max_skew 3, products 7 and 56.
REQ-036 TIMEOUT=2, WIDTH=4, mode 0 -> REPORT after 2 run cycles, timeout 1, skew 2, leak_now 1, no channel done.
REQ-037 Three leaking runs then clear_stats in the same cycle as a fourth, non-leaking REPORT -> leak 0, leak_count 0, max_skew 0; start pulses during RUN have no effect.
REQ-038 rst pulled low two cycles into RUN -> all outputs 0 immediately, no done; next start completes normally.
